// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types and constants.
// Used by the hazard, IF/ID, ID/EX and forwarding blocks.
package pipeline_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 64;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1
   } ctrl_state_e;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating performance counter with synchronous clear.
// Ports: clk, reset, inc, clr (wins over inc), count.
module hazard_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard/sequencing controller: load-use stall,
// taken-branch flush, imem wait; ports drive IF/ID, PC, ID/EX.
// Inputs: id_rs1/rs2/uses_rs2, ex_mem_read/rd, ex_branch_taken,
// imem_ready, perf_clr. Outputs: ifid_write, ifid_flush,
// pc_hold, idex_bubble, stall_cycles, flush_count, ctrl_state.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  imem_ready,
   input  logic                  perf_clr,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  pc_hold,
   output logic                  idex_bubble,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count,
   output logic [1:0]            ctrl_state
);

   localparam logic [1:0] CNT_INIT =
      2'(FLUSH_CYCLES - 1);

   ctrl_state_e state, state_n;
   logic [1:0]  cnt, cnt_n;

   logic load_use;
   logic rs1_hit, rs2_hit;
   logic br_acc;
   logic do_br, do_lu, do_im;

   assign rs1_hit = (ex_rd == id_rs1);
   assign rs2_hit = id_uses_rs2 && (ex_rd == id_rs2);

   assign load_use = ex_mem_read
                  && (ex_rd != REG_X0)
                  && (rs1_hit || rs2_hit);

   // Priority resolved into one-hot terms: branch beats
   // load-use beats the imem wait.
   assign do_br = ex_branch_taken;
   assign do_lu = !ex_branch_taken && load_use;
   assign do_im = !ex_branch_taken && !load_use
               && !imem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      pc_hold     = 1'b0;
      idex_bubble = 1'b0;
      br_acc      = 1'b0;
      if (reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         pc_hold     = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               unique case (1'b1)
                  do_br: begin
                     ifid_flush  = 1'b1;
                     idex_bubble = 1'b1;
                     br_acc      = 1'b1;
                     if (FLUSH_CYCLES > 1) begin
                        state_n = FLUSH;
                        cnt_n   = CNT_INIT;
                     end
                  end
                  do_lu: begin
                     ifid_write  = 1'b1;
                     pc_hold     = 1'b1;
                     idex_bubble = 1'b1;
                  end
                  do_im: begin
                     pc_hold    = 1'b1;
                     ifid_flush = 1'b1;
                  end
                  default: ;
               endcase
            end
            FLUSH: begin
               // Branches and load-use seen here are on
               // the wrong path and are ignored.
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               pc_hold     = !imem_ready;
               cnt_n       = cnt - 2'd1;
               if (cnt == 2'd1)
                  state_n = RUN;
            end
            default: begin
               state_n = RUN;
               cnt_n   = 2'd0;
            end
         endcase
      end
   end

   assign ctrl_state = state;

   hazard_perf_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_hold),
      .clr   (perf_clr),
      .count (stall_cycles)
   );

   hazard_perf_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (br_acc),
      .clr   (perf_clr),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed
// literal checks plus randomized traffic against a model.
module tb_pipeline_hazard_ctrl;

   localparam int FC  = 2;
   localparam int CW  = 5;
   localparam int SAT = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs1;
   logic [4:0]    id_rs2;
   logic          id_uses_rs2;
   logic          ex_mem_read;
   logic [4:0]    ex_rd;
   logic          ex_branch_taken;
   logic          imem_ready;
   logic          perf_clr;
   logic          ifid_write;
   logic          ifid_flush;
   logic          pc_hold;
   logic          idex_bubble;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] flush_count;
   logic [1:0]    ctrl_state;

   int checks = 0;
   int errors = 0;

   // Model: remaining FLUSH-only cycles, expected counters.
   int rem     = 0;
   int m_stall = 0;
   int m_flush = 0;
   bit m_ok    = 0;

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES (FC),
      .CNT_W        (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs2     (id_uses_rs2),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .imem_ready      (imem_ready),
      .perf_clr        (perf_clr),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .pc_hold         (pc_hold),
      .idex_bubble     (idex_bubble),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count),
      .ctrl_state      (ctrl_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   // Returns {ifid_write, ifid_flush, pc_hold, idex_bubble}.
   function automatic logic [3:0] exp_ctl();
      bit lu;
      lu = ex_mem_read && (ex_rd != 0)
        && (ex_rd == id_rs1
            || (id_uses_rs2 && ex_rd == id_rs2));
      if (reset)            return 4'b0111;
      if (rem > 0)
         return {1'b0, 1'b1, !imem_ready, 1'b1};
      if (ex_branch_taken)  return 4'b0101;
      if (lu)               return 4'b1011;
      if (!imem_ready)      return 4'b0110;
      return 4'b0000;
   endfunction

   always @(posedge clk) begin
      logic [3:0] c;
      bit acc;
      c = exp_ctl();
      if (reset) begin
         rem     = 0;
         m_stall = 0;
         m_flush = 0;
         m_ok    = 1;
      end else begin
         acc = (rem == 0) && ex_branch_taken;
         if (perf_clr) begin
            m_stall = 0;
            m_flush = 0;
         end else begin
            if (c[1] && m_stall < SAT) m_stall++;
            if (acc && m_flush < SAT)  m_flush++;
         end
         if (rem > 0)  rem--;
         else if (acc) rem = FC - 1;
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      if (m_ok) begin
         e = exp_ctl();
         check("ifid_write",  32'(ifid_write),  32'(e[3]));
         check("ifid_flush",  32'(ifid_flush),  32'(e[2]));
         check("pc_hold",     32'(pc_hold),     32'(e[1]));
         check("idex_bubble", 32'(idex_bubble), 32'(e[0]));
         check("ctrl_state",  32'(ctrl_state),
               (rem > 0) ? 32'd1 : 32'd0);
         check("stall_cycles", 32'(stall_cycles),
               32'(m_stall));
         check("flush_count", 32'(flush_count),
               32'(m_flush));
      end
   end

   task automatic idle();
      id_rs1          = 5'd1;
      id_rs2          = 5'd2;
      id_uses_rs2     = 1'b1;
      ex_mem_read     = 1'b0;
      ex_rd           = 5'd9;
      ex_branch_taken = 1'b0;
      imem_ready      = 1'b1;
      perf_clr        = 1'b0;
   endtask

   task automatic set_lu();
      ex_mem_read = 1'b1;
      ex_rd       = 5'd5;
      id_rs1      = 5'd5;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      nxt();
      @(negedge clk);
      check("rst_flush", 32'(ifid_flush), 1);
      check("rst_bubble", 32'(idex_bubble), 1);
      check("rst_hold", 32'(pc_hold), 1);
      check("rst_write", 32'(ifid_write), 0);
      check("rst_stall", 32'(stall_cycles), 0);
      nxt();
      reset = 1'b0;

      // Load-use stall: one cycle, counted once.
      set_lu();
      @(negedge clk);
      check("lu_write", 32'(ifid_write), 1);
      check("lu_hold", 32'(pc_hold), 1);
      check("lu_bubble", 32'(idex_bubble), 1);
      nxt();
      idle();
      @(negedge clk);
      check("lu_cnt", 32'(stall_cycles), 1);
      check("lu_done", 32'(pc_hold), 0);
      nxt();

      // x0 load and unused rs2 never stall.
      ex_mem_read = 1'b1;
      ex_rd       = 5'd0;
      id_rs1      = 5'd0;
      @(negedge clk);
      check("x0_hold", 32'(pc_hold), 0);
      nxt();
      ex_rd       = 5'd7;
      id_rs2      = 5'd7;
      id_rs1      = 5'd3;
      id_uses_rs2 = 1'b0;
      @(negedge clk);
      check("rs2_unused", 32'(pc_hold), 0);
      nxt();

      // Taken branch, then wrong-path branch + load-use.
      idle();
      ex_branch_taken = 1'b1;
      @(negedge clk);
      check("br_flush", 32'(ifid_flush), 1);
      check("br_hold", 32'(pc_hold), 0);
      nxt();
      set_lu();
      @(negedge clk);
      check("fl_flush", 32'(ifid_flush), 1);
      check("fl_write", 32'(ifid_write), 0);
      check("fl_state", 32'(ctrl_state), 1);
      check("fl_cnt", 32'(flush_count), 1);
      nxt();
      idle();
      @(negedge clk);
      check("fl_end", 32'(ifid_flush), 0);
      check("fl_cnt2", 32'(flush_count), 1);
      check("fl_stall", 32'(stall_cycles), 1);
      nxt();

      // Branch and load-use together: branch wins.
      set_lu();
      ex_branch_taken = 1'b1;
      @(negedge clk);
      check("bl_write", 32'(ifid_write), 0);
      check("bl_hold", 32'(pc_hold), 0);
      nxt();
      idle();
      nxt();
      @(negedge clk);
      check("bl_stall", 32'(stall_cycles), 1);
      check("bl_cnt", 32'(flush_count), 2);

      // Clear, then three imem wait cycles.
      perf_clr = 1'b1;
      nxt();
      perf_clr   = 1'b0;
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("im_hold", 32'(pc_hold), 1);
         check("im_flush", 32'(ifid_flush), 1);
         nxt();
      end
      idle();
      @(negedge clk);
      check("im_cnt", 32'(stall_cycles), 3);
      check("im_clr", 32'(flush_count), 0);
      nxt();

      // Reset in the middle of FLUSH.
      ex_branch_taken = 1'b1;
      nxt();
      idle();
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      @(negedge clk);
      check("mrst_state", 32'(ctrl_state), 0);
      check("mrst_stall", 32'(stall_cycles), 0);
      check("mrst_flush", 32'(flush_count), 0);
      nxt();

      // Saturation, then clear beating an increment.
      imem_ready = 1'b0;
      for (int i = 0; i < SAT + 8; i++) nxt();
      @(negedge clk);
      check("sat", 32'(stall_cycles), SAT);
      nxt();
      perf_clr = 1'b1;
      nxt();
      idle();
      @(negedge clk);
      check("clr_win", 32'(stall_cycles), 0);
      nxt();

      // Randomized traffic with narrow register ranges.
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 99) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         perf_clr        = ($urandom_range(0, 31) == 0);
         imem_ready      = ($urandom_range(0, 3) != 0);
         ex_mem_read     = 1'($urandom_range(0, 1));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         ex_rd           = 5'($urandom_range(0, 3));
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         nxt();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage 64-bit pipeline front end. It drives the IF/ID register's hold and flush inputs, the PC hold, and the ID/EX bubble select. It decides these from load-use hazards, taken branches resolved in EX, and instruction-memory readiness. It also keeps saturating stall and flush counters for performance debug.

## Interface
- FLUSH_CYCLES, default 1: number of cycles IF/ID is flushed after a taken branch (1..3).
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_rs1  in  5  rs1 of the instruction held in IF/ID.
- id_rs2  in  5  rs2 of the instruction held in IF/ID.
- id_uses_rs2  in  1  IF/ID instruction reads rs2.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rd  in  5  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- imem_ready  in  1  fetch data is valid this cycle.
- perf_clr  in  1  synchronous clear of both counters.
- ifid_write  out  1  1 = hold IF/ID contents (IF/ID loads when 0).
- ifid_flush  out  1  1 = zero IF/ID on the next edge.
- pc_hold  out  1  1 = PC keeps its value.
- idex_bubble  out  1  1 = zero ID/EX control fields.
- stall_cycles  out  CNT_W  cycles with pc_hold=1.
- flush_count  out  CNT_W  accepted taken branches.
- ctrl_state  out  2  FSM state, for debug.

## Operation
- States: RUN=0, FLUSH=1. Reset enters RUN. The flush countdown cnt (2 bits) resets to 0.
- load_use = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN outputs, in priority order:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_hold=0 (PC loads the target), ifid_write=0. flush_count increments. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  2. load_use: ifid_write=1, pc_hold=1, idex_bubble=1, ifid_flush=0.
  3. !imem_ready: pc_hold=1, ifid_flush=1 (a bubble enters IF/ID), idex_bubble=0.
  4. Otherwise all outputs are 0.
- FLUSH outputs: ifid_flush=1, idex_bubble=1, pc_hold=!imem_ready, ifid_write=0.
  - ex_branch_taken and load_use are ignored; ID/EX holds a bubble or a wrong-path instruction.
  - cnt decrements each cycle; when cnt==1, return to RUN on the next edge.
- Outputs are combinational from state and inputs.
- While reset=1, outputs are forced: ifid_flush=1, idex_bubble=1, pc_hold=1, ifid_write=0.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_hold=1.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both counters and wins over a same-cycle increment.
  - reset zeroes both counters.

## Timing
- Zero-cycle decision: outputs are valid in the same cycle as the inputs and act on the next clk edge.
- A load-use stall lasts exactly 1 cycle. After the bubble the load moves to MEM and load_use drops with no extra state.
- Taken branch: the wrong-path penalty is FLUSH_CYCLES+1 instruction slots (IF/ID flush plus ID/EX bubble).
- A taken branch in the same cycle as load_use is treated as the branch; the load-use instruction is wrong-path.
- A taken branch in the same cycle as !imem_ready still gives pc_hold=0, so the target is captured.
- Reset mid-FLUSH: state returns to RUN and cnt=0 on that edge.
- Counter increments are visible one cycle after the qualifying cycle.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, FLUSH);
  - REG_ADDR_W=5, XLEN=64, and the x0 constant;
  - shared with the IF/ID, ID/EX and forwarding blocks.
- Sub-module hazard_perf_counter: CNT_W saturating counter with inc and clr inputs, instantiated twice.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5 → ifid_write=1, pc_hold=1, idex_bubble=1 for 1 cycle; stall_cycles=1.
- ex_rd=0 with id_rs1=0 and a load → no stall. id_rs2 match with id_uses_rs2=0 → no stall.
- FLUSH_CYCLES=2: ex_branch_taken pulse → ifid_flush=1 for 2 cycles, pc_hold=0 in the first; flush_count=1; branch and load_use in the second cycle are ignored.
- ex_branch_taken and load_use in the same cycle → flush outcome, ifid_write=0, no extra stall cycle.
- imem_ready=0 for 3 cycles in RUN → pc_hold=1 and ifid_flush=1 for 3 cycles; stall_cycles=3. Reset asserted mid-FLUSH → RUN, counters 0.
- Preload stall_cycles to all-ones, then hold pc_hold=1 → the count stays all-ones. perf_clr together with an increment → 0.
